// File: rtl/inv_key_expansion.sv
// Iterative AES-128 inverse key schedule: walks from round key K_r back to the
// cipher key K_0, one round per clock, streaming every intermediate key.

module sub_byte (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module inv_key_expansion #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic [3:0]   start_round,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         done,
  output logic [127:0] key_out,
  output logic         err
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] NR_W = 4'(NR);

  state_t       state_reg, state_next;
  logic [127:0] cur_reg;
  logic [3:0]   idx_reg;
  logic [3:0]   idx_dec;
  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3;
  logic [7:0]   rcon;
  logic [127:0] step_key;
  logic         accept;
  logic         last_step;

  assign {a0, a1, a2, a3} = cur_reg;
  assign w3     = a3 ^ a2;
  assign w2     = a2 ^ a1;
  assign w1     = a1 ^ a0;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sub_byte u_sub (
        .a (rot_w3[gi*8 +: 8]),
        .s (sub_w3[gi*8 +: 8])
      );
    end
  endgenerate

  assign idx_dec = (idx_reg == 4'd0) ? 4'd0 : idx_reg - 4'd1;

  always_comb begin
    rcon = 8'h00;
    case (idx_dec)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0 = a0 ^ sub_w3 ^ {rcon, 24'h000000};
  // A start at round 0 has nothing to undo: the key passes straight through.
  assign step_key  = (idx_reg == 4'd0) ? cur_reg : {w0, w1, w2, w3};
  assign accept    = in_valid && (start_round <= NR_W);
  assign last_step = (idx_reg <= 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_reg  <= '0;
      idx_reg  <= '0;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_index <= '0;
      done     <= 1'b0;
      key_out  <= '0;
      err      <= 1'b0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (state_reg == IDLE) begin
        if (accept) begin
          cur_reg <= key_in;
          idx_reg <= start_round;
        end else if (in_valid) begin
          err <= 1'b1;
        end
      end else begin
        rk_valid <= 1'b1;
        rk_out   <= step_key;
        rk_index <= idx_dec;
        cur_reg  <= step_key;
        idx_reg  <= idx_dec;
        if (last_step) begin
          done    <= 1'b1;
          key_out <= step_key;
        end
      end
    end
  end
endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: FIPS-197 round-key chain as the reference, with a
// scoreboard queue of expected (key, index) pairs popped on every rk_valid.
`timescale 1ns/1ps

module tb_inv_key_expansion;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key_in;
  logic [3:0]   start_round;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         done;
  logic [127:0] key_out;
  logic         err;

  inv_key_expansion #(.NR(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .key_in      (key_in),
    .start_round (start_round),
    .rk_valid    (rk_valid),
    .rk_out      (rk_out),
    .rk_index    (rk_index),
    .done        (done),
    .key_out     (key_out),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   r;
  } vec_t;

  logic [127:0] fips_k [0:10];
  vec_t         vt [12];
  exp_t         sbq [$];
  int           n_vec = 0;
  int           n_err = 0;
  int           n_pulses;
  logic         done_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: sample 1ns after the rising edge and retire any emitted key.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (done) done_seen = 1'b1;
    if (rk_valid) begin
      n_pulses++;
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_rk: got index %0d key %h want no key", rk_index, rk_out);
      end else begin
        e = sbq.pop_front();
        check("rk_out", rk_out, e.key);
        check("rk_index", 128'(rk_index), 128'(e.idx));
        check("done_flag", 128'(done), 128'(e.idx == 4'd0));
        if (e.idx == 4'd0) begin
          check("key_out", key_out, e.key);
          check("in_ready_after_done", 128'(in_ready), 128'd1);
        end
      end
    end
  endtask

  // Issue one request; hold=1 keeps in_valid high with junk keys during RUN.
  task automatic run_vec(input logic [127:0] key, input logic [3:0] r, input bit hold);
    exp_t e;
    int   budget;
    check("in_ready_idle", 128'(in_ready), 128'd1);
    if (r == 4'd0) begin
      e.key = key; e.idx = 4'd0; sbq.push_back(e);
    end else begin
      for (int j = int'(r) - 1; j >= 0; j--) begin
        e.key = fips_k[j]; e.idx = 4'(j); sbq.push_back(e);
      end
    end
    in_valid    = 1'b1;
    key_in      = key;
    start_round = r;
    n_pulses    = 0;
    done_seen   = 1'b0;
    tick();
    if (hold) begin
      key_in      = {$urandom, $urandom, $urandom, $urandom};
      start_round = 4'($urandom_range(0, 10));
    end else begin
      in_valid = 1'b0;
    end
    budget = 0;
    while (!done_seen && budget < 30) begin
      if (budget > 0) check("in_ready_busy", 128'(in_ready), 128'd0);
      tick();
      budget++;
    end
    in_valid = 1'b0;
    check("latency", 128'(budget), (r == 4'd0) ? 128'd1 : 128'(r));
    check("pulse_count", 128'(n_pulses), (r == 4'd0) ? 128'd1 : 128'(r));
    check("queue_drained", 128'(sbq.size()), 128'd0);
    $display("vector key=%h r=%0d hold=%0d -> key_out=%h", key, r, hold, key_out);
  endtask

  initial begin
    fips_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vt[0].key = fips_k[10];                          vt[0].r = 4'd10;
    vt[1].key = fips_k[1];                           vt[1].r = 4'd1;
    vt[2].key = 128'h000102030405060708090a0b0c0d0e0f; vt[2].r = 4'd0;
    for (int i = 3; i < 12; i++) begin
      vt[i].key = fips_k[i - 1];
      vt[i].r   = 4'(i - 1);
    end

    rst_n = 1'b0; in_valid = 1'b0; key_in = '0; start_round = '0;
    done_seen = 1'b0; n_pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_rk_valid", 128'(rk_valid), 128'd0);
    check("rst_rk_out", rk_out, 128'd0);
    check("rst_key_out", key_out, 128'd0);
    check("rst_done_err", 128'({done, err, rk_index}), 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vt[i].key, vt[i].r, 1'b0);

    // Illegal start round: err pulse only, key_out from the previous request held.
    in_valid = 1'b1; key_in = fips_k[5]; start_round = 4'd11;
    n_pulses = 0;
    tick();
    check("err_pulse", 128'(err), 128'd1);
    check("err_in_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b0;
    tick();
    check("err_clears", 128'(err), 128'd0);
    check("err_key_out_held", key_out, fips_k[0]);
    check("err_no_rk", 128'(n_pulses), 128'd0);

    // Busy-ignores-in_valid, then a back-to-back request on the edge after done.
    run_vec(fips_k[10], 4'd10, 1'b1);
    run_vec(fips_k[1], 4'd1, 1'b0);

    // Reset in the middle of a run discards the request.
    in_valid = 1'b1; key_in = fips_k[10]; start_round = 4'd10;
    for (int j = 9; j >= 0; j--) begin
      exp_t e;
      e.key = fips_k[j]; e.idx = 4'(j); sbq.push_back(e);
    end
    n_pulses = 0;
    tick();
    in_valid = 1'b0;
    while (n_pulses < 4) tick();
    rst_n = 1'b0;
    #1;
    sbq.delete();
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_rk_valid", 128'(rk_valid), 128'd0);
    check("mid_rst_rk_out", rk_out, 128'd0);
    check("mid_rst_rk_index", 128'(rk_index), 128'd0);
    check("mid_rst_key_out", key_out, 128'd0);
    #1;
    rst_n = 1'b1;
    done_seen = 1'b0;
    n_pulses  = 0;
    repeat (15) tick();
    check("mid_rst_no_done", 128'(done_seen), 128'd0);
    check("mid_rst_no_rk", 128'(n_pulses), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
